// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state type, special key codes and the matrix position
// to key code mapping used by the keypad decoder.
package keypad_pkg;

  // Key event state machine states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_HOLD
  } kp_state_t;

  // Special keys: '#' confirms an entry, '*' clears it.
  localparam logic [3:0] KEY_CONFIRM = 4'hF;
  localparam logic [3:0] KEY_CLEAR   = 4'hE;

  // Keypad layout (row, column from 0):
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: * 0 # D
  function automatic logic [3:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = KEY_CLEAR;
      4'd13:   code = 4'h0;
      4'd14:   code = KEY_CONFIRM;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_decoder_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a bus of independent asynchronous bits.
// Each bit is synchronized on its own; no multi-bit coherence is implied.
module sync_2ff
  import keypad_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keypad_decoder.sv
// keypad_decoder: scans a 4x4 active-low matrix keypad, debounces whole-matrix
// scans and emits a one-cycle key_valid pulse per accepted key press.
// Optional feature macro: KEYPAD_REPEAT_EN -- while a key stays held, re-pulse
// key_valid every REPEAT_SCANS full scans. Without it, one event per press.
// Note: the column synchronizer adds two cycles of lag after each row change,
// so SCAN_DIV must be at least 3 for the sampled columns to match the row.
module keypad_decoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 20,
  parameter int REPEAT_SCANS   = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_matricial,
  output logic [3:0] lin_matricial,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  // Counters hold 0..N-1 and the action fires on the N-th qualifying scan,
  // so a $clog2(N) wide counter never needs to represent N itself.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_SCANS - 1);

  // Row scanning
  logic [DIV_W-1:0] div_cnt_reg;
  logic [1:0]       row_reg;
  logic [3:0]       lin_reg;
  logic [3:0]       col_sync;
  logic             sample_en;
  logic             scan_done;

  // Per-scan accumulation: hit count saturates at 2 ("more than one").
  logic [1:0] acc_cnt_reg;
  logic [3:0] acc_code_reg;
  logic [2:0] row_low_cnt;
  logic [1:0] row_col_idx;
  logic [1:0] row_hits;
  logic [2:0] hit_sum;
  logic [1:0] scan_hits;
  logic [3:0] scan_code;
  logic       scan_single;
  logic       scan_none;

  // Event state machine
  kp_state_t  state_reg, state_next;
  logic [3:0] cand_reg, cand_next;
  logic [DEB_W-1:0] deb_cnt_reg, deb_cnt_next;
  logic [3:0] key_code_reg, key_code_next;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_W = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_SCANS - 1);
  logic [RPT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
`endif

  sync_2ff #(
    .WIDTH    (4),
    .RESET_VAL(4'b1111)
  ) u_col_sync (
    .clk(clk),
    .rst(rst),
    .d  (col_matricial),
    .q  (col_sync)
  );

  assign sample_en = (div_cnt_reg == DIV_LAST);
  assign scan_done = sample_en && (row_reg == 2'd3);

  // Row period divider and one-cold row drive rotation (1110 -> 1101 -> ...).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg <= '0;
      row_reg     <= 2'd0;
      lin_reg     <= 4'b1110;
    end else if (sample_en) begin
      div_cnt_reg <= '0;
      row_reg     <= row_reg + 2'd1;
      lin_reg     <= {lin_reg[2:0], lin_reg[3]};
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  assign lin_matricial = lin_reg;

  // Count low columns in the currently driven row and remember the last one.
  always_comb begin
    row_low_cnt = 3'd0;
    row_col_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!col_sync[i]) begin
        row_low_cnt = row_low_cnt + 3'd1;
        row_col_idx = 2'(i);
      end
    end
  end

  assign row_hits    = (row_low_cnt > 3'd1) ? 2'd2 : row_low_cnt[1:0];
  assign hit_sum     = {1'b0, acc_cnt_reg} + {1'b0, row_hits};
  assign scan_hits   = (hit_sum > 3'd1) ? 2'd2 : hit_sum[1:0];
  assign scan_code   = (row_low_cnt == 3'd1) ? key_code_of(row_reg, row_col_idx) : acc_code_reg;
  // Only valid in the scan_done cycle: exactly one low bit over all four rows.
  assign scan_single = scan_done && (scan_hits == 2'd1);
  // Zero or several low bits both count as "no key".
  assign scan_none   = scan_done && (scan_hits != 2'd1);

  // Accumulate row samples over one full scan; restart after the last row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt_reg  <= 2'd0;
      acc_code_reg <= 4'h0;
    end else if (sample_en) begin
      if (row_reg == 2'd3) begin
        acc_cnt_reg  <= 2'd0;
        acc_code_reg <= 4'h0;
      end else begin
        acc_cnt_reg  <= scan_hits;
        acc_code_reg <= scan_code;
      end
    end
  end

  // Event FSM state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cand_reg     <= 4'h0;
      deb_cnt_reg  <= '0;
      key_code_reg <= 4'h0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_reg  <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      cand_reg     <= cand_next;
      deb_cnt_reg  <= deb_cnt_next;
      key_code_reg <= key_code_next;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_reg  <= rpt_cnt_next;
`endif
    end
  end

  // Event FSM next state: acts once per completed scan; EMIT lasts one cycle.
  // The debounce counter doubles as the release counter while in HOLD.
  always_comb begin
    state_next    = state_reg;
    cand_next     = cand_reg;
    deb_cnt_next  = deb_cnt_reg;
    key_code_next = key_code_reg;
    key_valid     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_next  = rpt_cnt_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (scan_single) begin
          cand_next    = scan_code;
          deb_cnt_next = '0;
          state_next   = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (scan_single && (scan_code == cand_reg)) begin
          if (deb_cnt_reg == DEB_LAST) begin
            key_code_next = cand_reg;
            state_next    = ST_EMIT;
          end else begin
            deb_cnt_next = deb_cnt_reg + DEB_W'(1);
          end
        end else if (scan_done) begin
          state_next = ST_IDLE;
        end
      end
      ST_EMIT: begin
        key_valid    = 1'b1;
        deb_cnt_next = '0;
`ifdef KEYPAD_REPEAT_EN
        rpt_cnt_next = '0;
`endif
        state_next   = ST_HOLD;
      end
      default: begin // ST_HOLD
        if (scan_none) begin
          if (deb_cnt_reg == DEB_LAST) begin
            state_next = ST_IDLE;
          end else begin
            deb_cnt_next = deb_cnt_reg + DEB_W'(1);
          end
`ifdef KEYPAD_REPEAT_EN
          rpt_cnt_next = '0;
`endif
        end else if (scan_single) begin
          // Any key seen breaks the release run; a different key is ignored.
          deb_cnt_next = '0;
`ifdef KEYPAD_REPEAT_EN
          if (scan_code != cand_reg) begin
            rpt_cnt_next = '0;
          end else if (rpt_cnt_reg == RPT_LAST) begin
            key_code_next = cand_reg;
            state_next    = ST_EMIT;
          end else begin
            rpt_cnt_next = rpt_cnt_reg + RPT_W'(1);
          end
`else
          // One event per press: a held key just keeps the block in HOLD.
          state_next = ST_HOLD;
`endif
        end
      end
    endcase
  end

  assign key_code = key_code_reg;

endmodule

// File: tb/tb_keypad_decoder.sv
// tb_keypad_decoder: drives a modelled keypad matrix scan by scan and checks the
// decoder every cycle against a scan-level behavioural model, plus pinned
// pulse counts / times / codes for directed press scenarios.
module tb_keypad_decoder;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int RPT      = 5;
  localparam int SCAN_CYC = 4 * SCAN_DIV;
`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_ZERO_PULSES = 4;
`else
  localparam int EXP_ZERO_PULSES = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] col_matricial;
  logic [3:0] lin_matricial;
  logic       key_valid;
  logic [3:0] key_code;

  logic [15:0] mask = 16'h0;   // pressed keys, bit index = row*4 + col
  logic [15:0] sched[$];       // one mask per full scan
  logic [3:0]  kmap[16];

  int errors = 0;
  int checks = 0;

  // Scan-level model state
  bit         m_hold;
  int         m_streak;
  logic [3:0] m_cand;
  logic [3:0] m_code;
  int         m_quiet;
  int         m_held;

  keypad_decoder #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_SCANS  (RPT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .col_matricial(col_matricial),
    .lin_matricial(lin_matricial),
    .key_valid    (key_valid),
    .key_code     (key_code)
  );

  always #5 clk = ~clk;

  // Passive keypad: a pressed key pulls its column low when its row is driven low.
  always_comb begin
    col_matricial = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!lin_matricial[r] && mask[r*4+c]) col_matricial[c] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Key code of a scan, or -1 when zero or several keys are down.
  function automatic int scan_result(input logic [15:0] m);
    if ($countones(m) != 1) return -1;
    for (int k = 0; k < 16; k++)
      if (m[k]) return int'(kmap[k]);
    return -1;
  endfunction

  task automatic model_reset();
    m_hold = 0; m_streak = -1; m_cand = 4'h0; m_code = 4'h0; m_quiet = 0; m_held = 0;
  endtask

  // Apply one completed scan to the model; ev=1 when a key event must follow.
  task automatic model_step(input int res, output bit ev);
    ev = 0;
    if (!m_hold) begin
      if (m_streak < 0) begin
        if (res >= 0) begin m_cand = 4'(res); m_streak = 0; end
      end else if (res == int'(m_cand)) begin
        m_streak++;
        if (m_streak == DEB) begin
          ev = 1; m_hold = 1; m_streak = -1; m_quiet = 0; m_held = 0; m_code = m_cand;
        end
      end else begin
        m_streak = -1;
      end
    end else if (res < 0) begin
      m_held = 0;
      m_quiet++;
      if (m_quiet == DEB) m_hold = 0;
    end else begin
      m_quiet = 0;
      if (res == int'(m_code)) begin
        m_held++;
`ifdef KEYPAD_REPEAT_EN
        if (m_held == RPT) begin ev = 1; m_held = 0; end
`endif
      end else begin
        m_held = 0;
      end
    end
  endtask

  // Assert reset for a few cycles checking reset outputs, release at a negedge.
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_code", key_code, 0);
      check("rst_lin", lin_matricial, 4'hE);
    end
    rst = 1'b0;
    model_reset();
  endtask

  // Run sched scan by scan (cycle 0 = current negedge, right after reset release).
  // stop_at >= 0 ends the run early at that cycle, leaving the mask as it is.
  task automatic run_scans(input int stop_at, output int npulse, output int first_at,
                           output int last_code);
    int          n_cyc;
    int          k;
    bit          ev;
    logic        exp_valid;
    logic [3:0]  exp_lin;
    logic [15:0] pm;
    npulse = 0; first_at = -1; last_code = -1;
    n_cyc = (stop_at >= 0) ? stop_at : SCAN_CYC * (sched.size() + 1);
    for (int i = 0; i < n_cyc; i++) begin
      if (i > 0) @(negedge clk);
      exp_valid = 1'b0;
      if ((i % SCAN_CYC == 0) && (i > 0)) begin
        k  = i / SCAN_CYC - 1;
        pm = (k < sched.size()) ? sched[k] : 16'h0;
        model_step(scan_result(pm), ev);
        exp_valid = ev;
      end
      exp_lin = ~(4'b0001 << ((i / SCAN_DIV) % 4));
      check("key_valid", key_valid, exp_valid);
      check("key_code", key_code, m_code);
      check("lin", lin_matricial, exp_lin);
      if (key_valid) begin
        npulse++;
        if (first_at < 0) first_at = i;
        last_code = key_code;
      end
      if (i % SCAN_CYC == 0) begin
        k    = i / SCAN_CYC;
        mask = (k < sched.size()) ? sched[k] : 16'h0;
      end
    end
  endtask

  task automatic push_n(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) sched.push_back(m);
  endtask

  initial begin
    int np, fa, lc, pick, a, b;
    logic [15:0] prev, m;
    kmap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
             4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    model_reset();

    // '5' (r1c1) held 10 scans: one pulse, 3 scans after the first stable scan.
    sched = {}; push_n(16'h0020, 10); push_n(16'h0, 5);
    reset_dut(); run_scans(-1, np, fa, lc);
    $display("press 5: pulses=%0d first_at=%0d code=%0h", np, fa, lc);
    check("p5_pulses", np, 1); check("p5_time", fa, 64); check("p5_code", lc, 5);

    // '#' (r3c2) bouncing for two scans, then stable.
    sched = {}; push_n(16'h4000, 1); push_n(16'h0, 1); push_n(16'h4000, 1); push_n(16'h0, 1);
    push_n(16'h4000, 8); push_n(16'h0, 5);
    reset_dut(); run_scans(-1, np, fa, lc);
    $display("press #: pulses=%0d first_at=%0d code=%0h", np, fa, lc);
    check("ph_pulses", np, 1); check("ph_time", fa, 128); check("ph_code", lc, 15);

    // r0c0 + r2c1 together (no event), then r2c1 released -> '1'.
    sched = {}; push_n(16'h0201, 4); push_n(16'h0001, 8); push_n(16'h0, 5);
    reset_dut(); run_scans(-1, np, fa, lc);
    $display("press 1+8 then 1: pulses=%0d first_at=%0d code=%0h", np, fa, lc);
    check("p1_pulses", np, 1); check("p1_time", fa, 128); check("p1_code", lc, 1);

    // '7' (r2c0) interrupted by reset during debounce, key kept held.
    sched = {}; push_n(16'h0100, 4);
    reset_dut(); run_scans(2 * SCAN_CYC + 5, np, fa, lc);
    $display("press 7 before reset: pulses=%0d", np);
    check("p7_pre_pulses", np, 0);
    sched = {}; push_n(16'h0100, 6); push_n(16'h0, 5);
    reset_dut(); run_scans(-1, np, fa, lc);
    $display("press 7 after reset: pulses=%0d first_at=%0d code=%0h", np, fa, lc);
    check("p7_pulses", np, 1); check("p7_time", fa, 64); check("p7_code", lc, 7);

    // '0' (r3c1) held 20 scans.
    sched = {}; push_n(16'h2000, 20); push_n(16'h0, 5);
    reset_dut(); run_scans(-1, np, fa, lc);
    $display("hold 0: pulses=%0d first_at=%0d code=%0h", np, fa, lc);
    check("p0_pulses", np, EXP_ZERO_PULSES); check("p0_time", fa, 64); check("p0_code", lc, 0);

    // Randomised scan sequences: runs of repeated masks, singles, doubles, none.
    for (int seg = 0; seg < 3; seg++) begin
      sched = {};
      prev  = 16'h0;
      for (int s = 0; s < 80; s++) begin
        if ($urandom_range(0, 99) < 80) begin
          m = prev;
        end else begin
          pick = $urandom_range(0, 3);
          a = $urandom_range(0, 15);
          b = $urandom_range(0, 15);
          if (pick == 0)      m = 16'h0;
          else if (pick == 3) m = (16'h1 << a) | (16'h1 << b);
          else                m = 16'h1 << a;
        end
        sched.push_back(m);
        prev = m;
      end
      push_n(16'h0, 5);
      reset_dut(); run_scans(-1, np, fa, lc);
      $display("random segment %0d: pulses=%0d", seg, np);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
